// File: rtl/bpsk_framer_pkg.sv
// Shared types and constants for the BPSK framer and its CRC helper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD
`ifdef FRAMER_CRC_EN
    , ST_CRC
`endif
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE     = 8'hAA;
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'h7E;
  localparam logic [7:0] CRC8_POLY         = 8'h07;

  // One MSB-first CRC-8 step: shift the register and fold in one message bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/bpsk_framer_if.sv
// Payload byte stream into the framer (valid/ready with a last-byte marker).
// Latency: n/a (wires only).
// Backpressure: byte_ready low holds the source; a byte moves on byte_valid && byte_ready.
interface bpsk_framer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, output byte_last, input byte_ready);
  modport slave  (input byte_in, input byte_valid, input byte_last, output byte_ready);
endinterface

// File: rtl/bpsk_framer_crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00, MSB first) over the payload bits.
// Latency: crc_next is combinational from the register and the current bit.
// Backpressure: none; en advances one bit per asserted cycle.
`ifdef FRAMER_CRC_EN
module crc8_serial
  import framer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc_next
);

  logic [7:0] crc_q;

  // crc_next already includes bit_in so the caller can send the final value
  // on the same edge that consumes the last payload bit.
  assign crc_next = crc8_step(crc_q, bit_in);

  // Running remainder: cleared between frames, advanced once per payload bit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_q <= 8'h00;
    end else if (en) begin
      crc_q <= crc_next;
    end
  end

endmodule
`endif

// File: rtl/bpsk_framer.sv
// BPSK frame serializer: preamble, sync word, payload (and CRC-8 when FRAMER_CRC_EN is defined).
// Latency: first preamble bit on data/mod_ena one cycle after frame_start; each bit held SAMPLES_PER_BIT cycles.
// Backpressure: one-byte holding register; byte_ready drops while it is full, an empty register at a byte boundary aborts with underrun.
module bpsk_framer
  import framer_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BIT = 16,
  parameter int unsigned PREAMBLE_BYTES  = 4,
  parameter logic [7:0]  SYNC_WORD       = DEFAULT_SYNC_WORD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  bpsk_framer_if.slave byte_if,
  output logic         data,
  output logic         mod_ena,
  output logic         busy,
  output logic         underrun
);

  localparam logic [7:0] SPB_LAST = 8'(SAMPLES_PER_BIT - 1);
  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_BYTES - 1);

  state_t     state;
  logic [7:0] sample_cnt;
  logic [2:0] bit_idx;
  logic [3:0] byte_cnt;
  logic [7:0] shift_reg;   // bit 7 is the bit currently on air
  logic [7:0] hold_dat;
  logic       hold_full;
  logic       hold_last;
  logic       last_seen;   // byte_last already accepted in this frame
  logic       cur_last;    // byte in shift_reg is the final payload byte
  logic       bit_end;
  logic       accept;

  assign bit_end  = (sample_cnt == SPB_LAST);
  assign data     = shift_reg[7];
  assign busy     = (state != ST_IDLE);
  assign accept   = byte_if.byte_valid && byte_if.byte_ready;
  assign byte_if.byte_ready = !hold_full && !last_seen &&
                              ((state == ST_SYNC) || (state == ST_PAYLOAD));

`ifdef FRAMER_CRC_EN
  logic [7:0] crc_next;
  logic       crc_clr;
  logic       crc_en;

  assign crc_clr = (state == ST_IDLE);
  assign crc_en  = (state == ST_PAYLOAD) && bit_end;

  crc8_serial u_crc (
    .clk      (clk),
    .rst      (rst),
    .clr      (crc_clr),
    .en       (crc_en),
    .bit_in   (data),
    .crc_next (crc_next)
  );
`endif

  // Framing FSM: bit timing, byte sequencing, holding-register handoff and frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sample_cnt <= 8'd0;
      bit_idx    <= 3'd0;
      byte_cnt   <= 4'd0;
      shift_reg  <= 8'h00;
      mod_ena    <= 1'b0;
      underrun   <= 1'b0;
      hold_dat   <= 8'h00;
      hold_full  <= 1'b0;
      hold_last  <= 1'b0;
      last_seen  <= 1'b0;
      cur_last   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          sample_cnt <= 8'd0;
          bit_idx    <= 3'd0;
          byte_cnt   <= 4'd0;
          shift_reg  <= 8'h00;
          mod_ena    <= 1'b0;
          hold_full  <= 1'b0;
          last_seen  <= 1'b0;
          cur_last   <= 1'b0;
          if (frame_start) begin
            state     <= ST_PREAMBLE;
            shift_reg <= PREAMBLE_BYTE;
            mod_ena   <= 1'b1;
          end
        end
        default: begin
          if (!bit_end) begin
            sample_cnt <= sample_cnt + 8'd1;
          end else begin
            sample_cnt <= 8'd0;
            if (bit_idx != 3'd7) begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {shift_reg[6:0], 1'b0};
            end else begin
              bit_idx <= 3'd0;
              case (state)
                ST_PREAMBLE: begin
                  if (byte_cnt == PRE_LAST) begin
                    state     <= ST_SYNC;
                    shift_reg <= SYNC_WORD;
                  end else begin
                    byte_cnt  <= byte_cnt + 4'd1;
                    shift_reg <= PREAMBLE_BYTE;
                  end
                end
                ST_SYNC, ST_PAYLOAD: begin
                  if ((state == ST_PAYLOAD) && cur_last) begin
`ifdef FRAMER_CRC_EN
                    state     <= ST_CRC;
                    shift_reg <= crc_next;
`else
                    state     <= ST_IDLE;
                    shift_reg <= 8'h00;
                    mod_ena   <= 1'b0;
`endif
                  end else if (hold_full) begin
                    state     <= ST_PAYLOAD;
                    shift_reg <= hold_dat;
                    cur_last  <= hold_last;
                    hold_full <= 1'b0;
                  end else begin
                    underrun  <= 1'b1;
                    state     <= ST_IDLE;
                    shift_reg <= 8'h00;
                    mod_ena   <= 1'b0;
                  end
                end
                // End of the CRC byte (or an unreachable encoding): close the frame.
                default: begin
                  state     <= ST_IDLE;
                  shift_reg <= 8'h00;
                  mod_ena   <= 1'b0;
                end
              endcase
            end
          end
          // Accept last so a byte taken on a boundary lands in the emptied register.
          if (accept) begin
            hold_dat  <= byte_if.byte_in;
            hold_last <= byte_if.byte_last;
            hold_full <= 1'b1;
            if (byte_if.byte_last) begin
              last_seen <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_framer.sv
// Self-checking bench for bpsk_framer: randomized payloads against a bit-level frame model.
// Latency: n/a (testbench).
// Backpressure: the byte feeder waits on byte_ready with bounded loops.
module tb_bpsk_framer;

  localparam int SPB     = 4;
  localparam int PRE     = 2;
  localparam int BIT_CYC = 8 * SPB;

  logic clk = 1'b0;
  logic rst;
  logic frame_start;
  logic data;
  logic mod_ena;
  logic busy;
  logic underrun;

  bpsk_framer_if bif ();

  bpsk_framer #(
    .SAMPLES_PER_BIT (SPB),
    .PREAMBLE_BYTES  (PRE),
    .SYNC_WORD       (8'h7E)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .byte_if     (bif),
    .data        (data),
    .mod_ena     (mod_ena),
    .busy        (busy),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ur_cnt   = 0;

  logic [7:0] pl_q[$];
  logic       exp_q[$];
  int         acc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (underrun === 1'b1) ur_cnt <= ur_cnt + 1;
  end

  // Frame model: preamble bytes, sync word, payload, optional CRC; each bit SPB cycles, MSB first.
  function automatic void build_expected();
    logic [7:0] bytes_q[$];
    logic [7:0] c;
    logic [7:0] cur;
    exp_q.delete();
    for (int i = 0; i < PRE; i++) bytes_q.push_back(8'hAA);
    bytes_q.push_back(8'h7E);
    foreach (pl_q[i]) bytes_q.push_back(pl_q[i]);
    c = 8'h00;
`ifdef FRAMER_CRC_EN
    foreach (pl_q[i]) begin
      c = c ^ pl_q[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    bytes_q.push_back(c);
`endif
    foreach (bytes_q[i]) begin
      cur = bytes_q[i];
      for (int b = 7; b >= 0; b--) repeat (SPB) exp_q.push_back(cur[b]);
    end
  endfunction

  // Drive one frame from pl_q, feeding bytes with random gaps while capturing the bitstream.
  task automatic run_frame(input int max_gap, input int rs_mid, input int rs_end,
                           output int len, output int errs, output int tmo);
    build_expected();
    acc_q.delete();
    errs = 0;
    tmo  = 0;
    len  = 0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fork
      begin : feed
        int g;
        int n;
        for (int i = 0; i < pl_q.size(); i++) begin
          g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
          if (g > 0) begin
            bif.byte_valid = 1'b0;
            repeat (g) @(negedge clk);
          end
          bif.byte_in    = pl_q[i];
          bif.byte_last  = (i == pl_q.size() - 1);
          bif.byte_valid = 1'b1;
          n = 0;
          while (bif.byte_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
          end
          if (n >= 400) tmo++;
          else acc_q.push_back(cyc);
          @(negedge clk);
        end
        bif.byte_valid = 1'b0;
        bif.byte_last  = 1'b0;
      end
      begin : cap
        int k;
        k = 0;
        while (mod_ena === 1'b1 && k < exp_q.size() + 50) begin
          if (k >= exp_q.size() || data !== exp_q[k]) errs++;
          frame_start = (k == rs_mid) || (k == rs_end);
          k++;
          @(negedge clk);
        end
        frame_start = 1'b0;
        len = k;
      end
    join
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (data !== 1'b0) begin n_fail++; $display("FAIL reset_data got %b want 0", data); end
    n_checks++; if (mod_ena !== 1'b0) begin n_fail++; $display("FAIL reset_mod_ena got %b want 0", mod_ena); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b want 0", underrun); end
    n_checks++; if (bif.byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready got %b want 0", bif.byte_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int len, errs, tmo, ur0;
    ur0 = ur_cnt;
    pl_q = '{8'h5A};
    run_frame(0, -1, -1, len, errs, tmo);
    n_checks++; if (len !== exp_q.size()) begin n_fail++; $display("FAIL directed_mod_ena_cycles got %0d want %0d", len, exp_q.size()); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL directed_bits got %0d bad cycles want 0", errs); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL directed_busy_after got %b want 0", busy); end
    n_checks++; if (ur_cnt - ur0 !== 0 || tmo !== 0) begin n_fail++; $display("FAIL directed_clean got underruns %0d timeouts %0d want 0 0", ur_cnt - ur0, tmo); end
  endtask

  task automatic test_random_frames();
    int len, errs, tmo, ur0, nb;
    for (int f = 0; f < 4; f++) begin
      ur0 = ur_cnt;
      pl_q.delete();
      nb = int'($urandom_range(4, 1));
      for (int i = 0; i < nb; i++) pl_q.push_back(8'($urandom));
      run_frame(10, -1, -1, len, errs, tmo);
      n_checks++; if (len !== exp_q.size()) begin n_fail++; $display("FAIL random%0d_len got %0d want %0d", f, len, exp_q.size()); end
      n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL random%0d_bits got %0d bad cycles want 0", f, errs); end
      n_checks++; if (ur_cnt - ur0 !== 0 || tmo !== 0) begin n_fail++; $display("FAIL random%0d_clean got underruns %0d timeouts %0d want 0 0", f, ur_cnt - ur0, tmo); end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int len, errs, tmo, bad;
    pl_q.delete();
    for (int i = 0; i < 5; i++) pl_q.push_back(8'($urandom));
    run_frame(0, -1, -1, len, errs, tmo);
    bad = 0;
    for (int i = 1; i < acc_q.size(); i++) if (acc_q[i] - acc_q[i-1] != BIT_CYC) bad++;
    n_checks++; if (len !== exp_q.size()) begin n_fail++; $display("FAIL b2b_len got %0d want %0d", len, exp_q.size()); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL b2b_bits got %0d bad cycles want 0", errs); end
    n_checks++; if (bad !== 0 || acc_q.size() !== 5) begin n_fail++; $display("FAIL b2b_accept_spacing got %0d bad gaps %0d accepts want 0 5", bad, acc_q.size()); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    int len, errs, tmo;
    pl_q.delete();
    for (int i = 0; i < 3; i++) pl_q.push_back(8'($urandom));
    build_expected();
    run_frame(4, (PRE + 2) * BIT_CYC + 5, exp_q.size() - 1, len, errs, tmo);
    n_checks++; if (len !== exp_q.size()) begin n_fail++; $display("FAIL restart_len got %0d want %0d", len, exp_q.size()); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL restart_bits got %0d bad cycles want 0", errs); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || mod_ena !== 1'b0) begin n_fail++; $display("FAIL restart_end_start got busy %b mod_ena %b want 0 0", busy, mod_ena); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_underrun();
    int k, ur0;
    ur0 = ur_cnt;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    k = 0;
    while (mod_ena === 1'b1 && k < 1000) begin
      k++;
      @(negedge clk);
    end
    n_checks++; if (k !== (PRE + 1) * BIT_CYC) begin n_fail++; $display("FAIL underrun_mod_ena_cycles got %0d want %0d", k, (PRE + 1) * BIT_CYC); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_pulse got %b want 1", underrun); end
    n_checks++; if (busy !== 1'b0 || data !== 1'b0) begin n_fail++; $display("FAIL underrun_idle got busy %b data %b want 0 0", busy, data); end
    bif.byte_in    = 8'h01;
    bif.byte_last  = 1'b1;
    bif.byte_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (underrun !== 1'b0 || ur_cnt - ur0 !== 1) begin n_fail++; $display("FAIL underrun_once got level %b count %0d want 0 1", underrun, ur_cnt - ur0); end
    n_checks++; if (bif.byte_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL underrun_no_accept got ready %b busy %b want 0 0", bif.byte_ready, busy); end
    bif.byte_valid = 1'b0;
    bif.byte_last  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int len, errs, tmo, ur0;
    ur0 = ur_cnt;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (5 * SPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (mod_ena !== 1'b0 || data !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs got mod_ena %b data %b busy %b want 0 0 0", mod_ena, data, busy); end
    n_checks++; if (underrun !== 1'b0 || bif.byte_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got underrun %b ready %b want 0 0", underrun, bif.byte_ready); end
    @(negedge clk);
    n_checks++; if (ur_cnt - ur0 !== 0) begin n_fail++; $display("FAIL midrst_no_underrun got %0d want 0", ur_cnt - ur0); end
    pl_q.delete();
    pl_q.push_back(8'($urandom));
    pl_q.push_back(8'($urandom));
    run_frame(6, -1, -1, len, errs, tmo);
    n_checks++; if (len !== exp_q.size() || errs !== 0) begin n_fail++; $display("FAIL midrst_next_frame got len %0d bad %0d want %0d 0", len, errs, exp_q.size()); end
    repeat (2) @(negedge clk);
  endtask

`ifdef FRAMER_CRC_EN
  task automatic test_crc();
    int len, errs, tmo;
    pl_q = '{8'h31, 8'h32, 8'h33};
    run_frame(0, -1, -1, len, errs, tmo);
    n_checks++; if (len !== exp_q.size()) begin n_fail++; $display("FAIL crc_len got %0d want %0d", len, exp_q.size()); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL crc_bits got %0d bad cycles want 0", errs); end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    rst            = 1'b1;
    frame_start    = 1'b0;
    bif.byte_in    = 8'h00;
    bif.byte_valid = 1'b0;
    bif.byte_last  = 1'b0;
    test_reset();
    test_directed();
    test_random_frames();
    test_back_to_back();
    test_restart_ignored();
    test_underrun();
    test_reset_mid_frame();
`ifdef FRAMER_CRC_EN
    test_crc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
